// File: rtl/uart_tx_if.sv
// CPU-side write port of the UART transmit path: byte/strobe in, FIFO status out.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       CPU_write;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  modport master (output data_in, CPU_write, input fifo_full, fifo_empty, overflow);
  modport slave  (input data_in, CPU_write, output fifo_full, fifo_empty, overflow);
endinterface

// File: rtl/uart_tx_path.sv
// UART transmit path: TX FIFO feeding a bit-rate counter and frame FSM (8N1, LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_path #(
  parameter int F_SYS      = 50000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  input  logic [3:0] baud_rate,
  output logic       tx,
  output logic       tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(F_SYS / 2400 + 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         r_state, w_nstate;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit;
  logic [DW-1:0]  r_div, r_cnt;
  logic           r_tx, r_busy;
`ifdef UART_TX_PARITY_EN
  logic           r_par;
`endif
  logic           w_wr, w_pop, w_bit_end, w_tx;
  logic [DW-1:0]  w_div_sel;

  // Divisor for the selected rate; unlisted codes fall back to 9600.
  always_comb begin
    case (baud_rate)
      4'd0:    w_div_sel = DW'(F_SYS / 2400);
      4'd1:    w_div_sel = DW'(F_SYS / 4800);
      4'd2:    w_div_sel = DW'(F_SYS / 9600);
      4'd3:    w_div_sel = DW'(F_SYS / 19200);
      4'd4:    w_div_sel = DW'(F_SYS / 38400);
      4'd5:    w_div_sel = DW'(F_SYS / 57600);
      4'd6:    w_div_sel = DW'(F_SYS / 115200);
      default: w_div_sel = DW'(F_SYS / 9600);
    endcase
  end

  assign bus.fifo_full  = (r_count == CW'(FIFO_DEPTH));
  assign bus.fifo_empty = (r_count == '0);
  assign bus.overflow   = r_overflow;
  assign w_wr           = bus.CPU_write && !bus.fifo_full;
  assign w_bit_end      = (r_cnt == r_div - 1'b1);
  assign tx             = r_tx;
  assign tx_busy        = r_busy;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.CPU_write && bus.fifo_full;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    w_tx     = 1'b1;
    case (r_state)
      IDLE: if (!bus.fifo_empty) begin
        w_pop    = 1'b1;
        w_nstate = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_nstate = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
        if (w_bit_end && r_bit == 3'd7) w_nstate = PARITY;
`else
        if (w_bit_end && r_bit == 3'd7) w_nstate = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx = r_par;
        if (w_bit_end) w_nstate = STOP;
      end
`endif
      STOP: if (w_bit_end) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // tx/tx_busy are registered copies of the state decode, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_div   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_tx   <= w_tx;
      r_busy <= (r_state != IDLE);
      if (r_state == IDLE || w_bit_end) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 1'b1;
      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
        r_div   <= w_div_sel;
        r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^r_mem[r_rptr];
`endif
      end else if (r_state == DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_path.sv
// Scoreboard bench for uart_tx_path: stimulus queues expected frames, a monitor decodes tx.
module tb_uart_tx_path;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] baud_rate = 4'd6;
  logic       tx, tx_busy;

  uart_tx_if u_if();

  uart_tx_path #(.F_SYS(50000000), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus(u_if.slave),
    .baud_rate(baud_rate), .tx(tx), .tx_busy(tx_busy)
  );

  always #10 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct { logic [7:0] d; int div; } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [7:0] d, input int div, input bit push);
    u_if.data_in   = d;
    u_if.CPU_write = 1'b1;
    if (push) q.push_back('{d, div});
    @(negedge clk);
    u_if.CPU_write = 1'b0;
  endtask

  task automatic wait_busy(input bit want, input int bound, output int n);
    n = 0;
    while (tx_busy !== want && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout waiting tx_busy=%0d after %0d cycles", want, n);
    end
  endtask

  task automatic reset_mid_frame(input string tag);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk({tag, "_tx"}, tx, 1'b1);
    chk({tag, "_busy"}, tx_busy, 1'b0);
    chk({tag, "_empty"}, u_if.fifo_empty, 1'b1);
    chk({tag, "_full"}, u_if.fifo_full, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    chk({tag, "_tx_idle"}, tx, 1'b1);
    chk({tag, "_still_empty"}, u_if.fifo_empty, 1'b1);
  endtask

  // Monitor: decode each frame from the line, compare against the queue head.
  bit prev_tx = 1'b1;
  always begin
    exp_t e;
    logic [10:0] bits;
    bit abort;
    @(negedge clk);
    if (!reset && prev_tx && tx === 1'b0) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame: start bit with no queued byte at %0t", $time);
      end else begin
        e = q.pop_front();
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = e.d;
        if (NB == 11) bits[9] = ^e.d;
        abort = 1'b0;
        chk("mon_busy_at_start", tx_busy, 1'b1);
        for (int b = 0; b < NB; b++) begin
          for (int c = 0; c < e.div; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (reset) begin abort = 1'b1; break; end
            if (c == 0 || c == e.div - 1)
              chk($sformatf("mon_bit%0d_byte%02h", b, e.d), tx, bits[b]);
          end
          if (abort) break;
        end
        if (!abort) begin
          @(negedge clk);
          if (!reset) chk("mon_idle_after_stop", tx, 1'b1);
        end
      end
    end
    prev_tx = tx;
  end

  initial begin
    int n;
    u_if.data_in   = '0;
    u_if.CPU_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_full", u_if.fifo_full, 1'b0);
    chk("rst_empty", u_if.fifo_empty, 1'b1);
    chk("rst_overflow", u_if.overflow, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5 into empty FIFO: pop at N+1, start bit from N+2, 10*434 clocks busy.
    wr(8'hA5, 434, 1'b1);
    chk("t1_empty_after_write", u_if.fifo_empty, 1'b0);
    chk("t1_tx_idle_n", tx, 1'b1);
    @(negedge clk);
    chk("t1_tx_idle_n1", tx, 1'b1);
    chk("t1_busy_n1", tx_busy, 1'b0);
    chk("t1_empty_after_pop", u_if.fifo_empty, 1'b1);
    @(negedge clk);
    chk("t1_start_n2", tx, 1'b0);
    chk("t1_busy_n2", tx_busy, 1'b1);
    wait_busy(1'b0, 20000, n);
    chk("t1_frame_len", n, 4340);
    repeat (5) @(negedge clk);

    // 0x07: parity bit (if built in) is 1; frame length depends on build.
    wr(8'h07, 434, 1'b1);
    wait_busy(1'b1, 10, n);
    wait_busy(1'b0, 20000, n);
`ifdef UART_TX_PARITY_EN
    chk("t6_frame_len", n, 4774);
`else
    chk("t6_frame_len", n, 4340);
`endif
    repeat (5) @(negedge clk);

    // Three bytes back-to-back: one idle clock between frames.
    wr(8'h01, 434, 1'b1);
    wr(8'h02, 434, 1'b1);
    wr(8'h03, 434, 1'b1);
    chk("t2_empty_queued", u_if.fifo_empty, 1'b0);
    wait_busy(1'b1, 10, n);
    for (int f = 0; f < 3; f++) begin
      wait_busy(1'b0, 20000, n);
      chk($sformatf("t2_frame%0d_len", f), n, 4340);
      if (f < 2) begin
        wait_busy(1'b1, 100, n);
        chk($sformatf("t2_gap%0d", f), n, 1);
      end
    end
    chk("t2_empty_end", u_if.fifo_empty, 1'b1);
    repeat (5) @(negedge clk);

    // Fill 16 behind an active frame, 17th write overflows, then reset during DATA bit 3.
    wr(8'h3C, 434, 1'b1);
    wait_busy(1'b1, 10, n);
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 434, 1'b1);
    chk("t3_full", u_if.fifo_full, 1'b1);
    chk("t3_no_ovf_yet", u_if.overflow, 1'b0);
    wr(8'hEE, 434, 1'b0);
    chk("t3_overflow_pulse", u_if.overflow, 1'b1);
    chk("t3_still_full", u_if.fifo_full, 1'b1);
    @(negedge clk);
    chk("t3_overflow_clear", u_if.overflow, 1'b0);
    n = 0;
    while (u_if.fifo_full && n < 6000) begin @(negedge clk); n++; end
    chk("t3_full_drops_after_one_pop", u_if.fifo_full, 1'b0);
    chk("t3_not_empty", u_if.fifo_empty, 1'b0);
    @(negedge clk);
    chk("t3_next_start", tx, 1'b0);
    repeat (4 * 434 + 217) @(negedge clk);
    reset_mid_frame("t5_reset");

    // Rate change mid-frame: first frame keeps 434, next latches 5208.
    wr(8'h5A, 434, 1'b1);
    wr(8'hC3, 5208, 1'b1);
    wait_busy(1'b1, 10, n);
    repeat (1000) @(negedge clk);
    baud_rate = 4'd2;
    wait_busy(1'b0, 20000, n);
    chk("t4_frame1_len", n + 1000, 4340);
    wait_busy(1'b1, 100, n);
    chk("t4_gap", n, 1);
    repeat (4 * 5208) @(negedge clk);
    chk("t4_still_busy", tx_busy, 1'b1);
    reset_mid_frame("t4_reset");
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
